// File: rtl/process_element_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NUM_REQ requesters.
// A tag pipeline follows each operation through the multiplier so that each product
// is returned with the ID of the requester that issued it.
// Optional build macro PE_MUL_ARB_STATS_EN adds the stat_clr input and the
// saturating stat_issued / stat_stall counters.
module process_element_mul_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned din0_WIDTH  = 16,
    parameter int unsigned din1_WIDTH  = 8,
    parameter int unsigned dout_WIDTH  = 24,
    parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
`ifdef PE_MUL_ARB_STATS_EN
    input  logic                          stat_clr,
    output logic [31:0]                   stat_issued,
    output logic [31:0]                   stat_stall,
`endif
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*din0_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*din1_WIDTH-1:0] req_b,
    output logic                          mul_ce,
    output logic [din0_WIDTH-1:0]         mul_din0,
    output logic [din1_WIDTH-1:0]         mul_din1,
    input  logic [dout_WIDTH-1:0]         mul_dout,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ID_W-1:0]               res_id,
    output logic [dout_WIDTH-1:0]         res_data
);

    logic [MUL_LATENCY-1:0] tag_vld_q;
    logic [ID_W-1:0]        tag_id_q [MUL_LATENCY];
    logic [ID_W-1:0]        last_grant_q;

    logic                   stall;
    logic                   found;
    logic                   grant_valid;
    logic [ID_W-1:0]        grant_id;
    logic [ID_W-1:0]        cand;

    // Stall only when a finished result is waiting on the consumer; reset flushes freely.
    always_comb begin
        stall  = tag_vld_q[MUL_LATENCY-1] & ~res_ready & ~reset;
        mul_ce = ~stall;
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last_grant_q) + k) % NUM_REQ);
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && cand == ID_W'(i) && req_valid[i]) begin
                    found    = 1'b1;
                    grant_id = cand;
                end
            end
        end
        grant_valid = found & ~stall & ~reset;
    end

    // Winner's ready and operands; bubbles drive zeros into the multiplier.
    always_comb begin
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && grant_id == ID_W'(i)) begin
                req_ready[i] = 1'b1;
                mul_din0     = req_a[i*din0_WIDTH +: din0_WIDTH];
                mul_din1     = req_b[i*din1_WIDTH +: din1_WIDTH];
            end
        end
    end

    // Tag pipeline mirrors the multiplier: shifts only on enabled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld_q <= '0;
            for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
        end else if (mul_ce) begin
            tag_vld_q[0] <= grant_valid;
            tag_id_q[0]  <= grant_valid ? grant_id : '0;
            for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    // Remember the last winner; reset value makes requester 0 win first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else if (grant_valid) begin
            last_grant_q <= grant_id;
        end
    end

    // Result channel taps the last tag stage; data holds because the multiplier is stalled.
    always_comb begin
        res_valid = tag_vld_q[MUL_LATENCY-1] & ~reset;
        res_id    = tag_id_q[MUL_LATENCY-1];
        res_data  = mul_dout;
    end

`ifdef PE_MUL_ARB_STATS_EN
    // Saturating handshake and stall counters; clear wins over increment.
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (grant_valid && stat_issued != 32'hFFFF_FFFF) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (stall && stat_stall != 32'hFFFF_FFFF) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
